countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//   BCD mm:ss countdown timer. Consumes the divider's div_hsec level (toggles every 0.5 s).
//   Converts each rising edge of that level into a 1 s tick in the clk domain.
//   Drives digit values to the seven-segment scan stage and alarm/flash status to the LEDs.
// PARAMETERS
//   DEF_MIN   8'h01  BCD minutes preset at reset (reload source)
//   DEF_SEC   8'h30  BCD seconds preset at reset (reload source)
//   WARN_SEC  8'h10  BCD seconds threshold for warn; used only with TIMER_WARN_EN
// PORTS
//   clk       in   1  system clock, 100 MHz; the only clock
//   rst       in   1  synchronous, active-high reset
//   hsec_in   in   1  div_hsec level from the clock divider; never used as a clock
//   start     in   1  one-cycle pulse (debounced upstream): run / resume / restart
//   pause     in   1  one-cycle pulse: pause while running
//   load      in   1  one-cycle pulse: capture load_min/load_sec
//   load_min  in   8  BCD minutes {tens,ones}
//   load_sec  in   8  BCD seconds {tens,ones}
//   min_bcd   out  8  current minutes, BCD
//   sec_bcd   out  8  current seconds, BCD
//   running   out  1  1 in RUN state
//   expired   out  1  one-cycle pulse when the count reaches 00:00
//   alarm     out  1  1 in EXPIRED state
//   flash     out  1  alarm & hsec_in (1 Hz blink)
//   warn      out  1  present only with TIMER_WARN_EN
// BEHAVIOUR
//   Reset: state=IDLE. min_bcd/reload_min=DEF_MIN, sec_bcd/reload_sec=DEF_SEC. All 1-bit outputs 0. hsec_q=1.
//   Tick: hsec_q<=hsec_in each cycle; tick = hsec_in & ~hsec_q.
//     With hsec_q=1 at reset, a high hsec_in at reset release gives no tick.
//   Counter latency: the count updates on the clk edge after the cycle in which tick=1.
//   Command priority, same cycle: load > pause > start.
//   States:
//     IDLE: load -> capture clamped values into count and reload regs; stay IDLE.
//           start with count != 00:00 -> RUN. start with count == 00:00 -> ignored.
//     RUN: tick -> BCD decrement.
//          pause -> PAUSE; a tick in the same cycle is dropped.
//          load and start ignored.
//          decrement from 00:01 -> count=00:00, expired=1 for 1 cycle, next state EXPIRED.
//     PAUSE: start -> RUN. load -> capture, go to IDLE. ticks ignored.
//     EXPIRED: alarm=1. load -> capture, go to IDLE, alarm=0.
//              start -> count=reload regs, go to RUN.
//   BCD decrement:
//     sec ones 0->9 borrow; sec tens 0->5 borrow; min ones 0->9 borrow; min tens decrements.
//     Maximum count 99:59. No wrap below 00:00.
//   Load clamp, per digit: sec tens >5 -> 5; any other digit >9 -> 9.
//   First second after start is partial; tick phase is never re-aligned.
//   rst asserted in any state, mid-count included, restores the reset values on the next edge.
// CONFIGURATION
//   TIMER_WARN_EN defined:
//     warn output port exists.
//     warn=1 (registered) while RUN or PAUSE and count <= {8'h00,WARN_SEC}.
//     Reset value 0.
//   TIMER_WARN_EN undefined: warn port and compare logic absent. All other behaviour identical.
// TESTING
//   Drive hsec_in from a bench toggle every 10 clk, with rst for 3 cycles.
//   T1: reset, then start, then 2 rising edges of hsec_in -> 01:30 -> 01:28; running=1.
//   T2: load 00:02, start, 2 ticks -> 00:01 then 00:00; expired high 1 cycle; alarm=1;
//       flash follows hsec_in.
//   T3: RUN at 00:45, pause asserted in a tick cycle -> stays 00:45 through 3 ticks;
//       start resumes; next tick -> 00:44.
//   T4: load 8'h10 / 8'h00, one tick -> 09:59. Load 8'hAF / 8'h7C -> 99:59 after clamp.
//   T5: EXPIRED after load 00:03, start -> count 00:03 and RUN.
//       Load+pause+start in the same cycle in RUN -> only pause acts.
//   T6: rst asserted mid-count at 00:17 -> 01:30, IDLE, alarm=0.
//       hsec_in=1 at reset release gives no tick.
//       With TIMER_WARN_EN: warn rises at 00:10.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer driven by the divider's half-second level.
// Optional registered warn output is built only when TIMER_WARN_EN is defined.
module countdown_timer #(
    parameter logic [7:0] DEF_MIN  = 8'h01,
    parameter logic [7:0] DEF_SEC  = 8'h30,
    parameter logic [7:0] WARN_SEC = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       alarm,
    output logic       flash
`ifdef TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] reload_q, reload_d;
    logic        hsec_q;
    logic        expired_q, expired_d;
    logic        tick;
    logic [15:0] load_clamped;

    // One-second decrement with per-digit borrow; 00:00 stays put.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (c != 16'h0000) begin
            if (so != 4'd0) begin
                so = so - 4'd1;
            end else begin
                so = 4'd9;
                if (st != 4'd0) begin
                    st = st - 4'd1;
                end else begin
                    st = 4'd5;
                    if (mo != 4'd0) begin
                        mo = mo - 4'd1;
                    end else begin
                        mo = 4'd9;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] clamp_load(input logic [7:0] m, input logic [7:0] s);
        logic [3:0] mt, mo, st, so;
        mt = (m[7:4] > 4'd9) ? 4'd9 : m[7:4];
        mo = (m[3:0] > 4'd9) ? 4'd9 : m[3:0];
        st = (s[7:4] > 4'd5) ? 4'd5 : s[7:4];
        so = (s[3:0] > 4'd9) ? 4'd9 : s[3:0];
        return {mt, mo, st, so};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= {DEF_MIN, DEF_SEC};
            reload_q  <= {DEF_MIN, DEF_SEC};
            hsec_q    <= 1'b1;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            hsec_q    <= hsec_in;
            expired_q <= expired_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        reload_d     = reload_q;
        expired_d    = 1'b0;
        tick         = hsec_in & ~hsec_q;
        load_clamped = clamp_load(load_min, load_sec);
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    count_d  = load_clamped;
                    reload_d = load_clamped;
                end else if (start && count_q != 16'h0000) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Pause wins over a coincident tick; load and start have no effect here.
                if (pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    count_d = bcd_dec(count_q);
                    if (count_q == 16'h0001) begin
                        expired_d = 1'b1;
                        state_d   = S_EXPIRED;
                    end
                end
            end
            S_PAUSE: begin
                if (load) begin
                    count_d  = load_clamped;
                    reload_d = load_clamped;
                    state_d  = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_EXPIRED: begin
                if (load) begin
                    count_d  = load_clamped;
                    reload_d = load_clamped;
                    state_d  = S_IDLE;
                end else if (start) begin
                    count_d = reload_q;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        min_bcd = count_q[15:8];
        sec_bcd = count_q[7:0];
        running = (state_q == S_RUN);
        alarm   = (state_q == S_EXPIRED);
        expired = expired_q;
        flash   = (state_q == S_EXPIRED) & hsec_in;
    end

`ifdef TIMER_WARN_EN
    logic warn_q;

    // Computed from next-state values so warn changes on the same edge as the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= (state_d == S_RUN || state_d == S_PAUSE) &&
                      (count_d <= {8'h00, WARN_SEC});
        end
    end

    assign warn = warn_q;
`endif

endmodule
